// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles, branch redirects, memory freezes.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_BranchTaken,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        DMem_Ready,
  output logic        DMem_Req,
  output logic        PC_Ld,
  output logic        IFID_Ld,
  output logic        IDEX_Ld,
  output logic        EXMEM_Ld,
  output logic        MEMWB_Ld,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic        MEMWB_Flush,
  output logic        MemTimeout,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             memacc, loaduse;

  assign memacc  = MEM_MemRead | MEM_MemWrite;
  assign loaduse = EX_MemRead & (EX_WriteReg != 5'd0) &
                   ((EX_WriteReg == ID_Rs) | (ID_UsesRt & (EX_WriteReg == ID_Rt)));

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    DMem_Req      = 1'b0;
    PC_Ld         = 1'b1;
    IFID_Ld       = 1'b1;
    IDEX_Ld       = 1'b1;
    EXMEM_Ld      = 1'b1;
    MEMWB_Ld      = 1'b1;
    IFID_Flush    = 1'b0;
    IDEX_Flush    = 1'b0;
    EXMEM_Flush   = 1'b0;
    MEMWB_Flush   = 1'b0;
    if (Rst) begin
      // Reset also aborts any outstanding memory access.
      {PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld}      = '0;
      {IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush} = '1;
      state_d       = StRun;
      wcnt_d        = '0;
      mem_timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          DMem_Req = memacc;
          if (memacc && !DMem_Ready) begin
            {PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld} = '0;
            MEMWB_Flush = 1'b1;
            state_d     = StMemWait;
            wcnt_d      = CNT_W'(1);
          end else if (EX_BranchTaken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (loaduse) begin
            PC_Ld      = 1'b0;
            IFID_Ld    = 1'b0;
            IDEX_Flush = 1'b1;
          end
        end
        StMemWait: begin
          DMem_Req = 1'b1;
          if (DMem_Ready) begin
            state_d = StRun;
            wcnt_d  = '0;
          end else if (wcnt_q == CNT_W'(MEM_TIMEOUT)) begin
            // Forced completion: release the pipe and flag the overrun.
            mem_timeout_d = 1'b1;
            state_d       = StRun;
            wcnt_d        = '0;
          end else begin
            {PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld} = '0;
            MEMWB_Flush = 1'b1;
            wcnt_d      = wcnt_q + CNT_W'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    state_q       <= state_d;
    wcnt_q        <= wcnt_d;
    mem_timeout_q <= mem_timeout_d;
  end

  assign MemTimeout = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        branch_flush;

  assign branch_flush = !Rst && (state_q == StRun) && !(memacc && !DMem_Ready) && EX_BranchTaken;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PC_Ld)       stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: expected control vectors are queued as
// stimulus is applied and compared against the DUT mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
  logic        ID_UsesRt, EX_MemRead, EX_BranchTaken;
  logic        MEM_MemRead, MEM_MemWrite, DMem_Ready;
  logic        DMem_Req, PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld;
  logic        IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush, MemTimeout;
  logic [31:0] StallCycles, FlushCount;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .DMem_Ready(DMem_Ready),
    .DMem_Req(DMem_Req), .PC_Ld(PC_Ld), .IFID_Ld(IFID_Ld), .IDEX_Ld(IDEX_Ld),
    .EXMEM_Ld(EXMEM_Ld), .MEMWB_Ld(MEMWB_Ld), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .MEMWB_Flush(MEMWB_Flush),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  // {DMem_Req, PC,IFID,IDEX,EXMEM,MEMWB Ld, IFID,IDEX,EXMEM,MEMWB Flush}
  localparam logic [9:0] RESET_P   = 10'b0_00000_1111;
  localparam logic [9:0] NORMAL_P  = 10'b0_11111_0000;
  localparam logic [9:0] LOADUSE_P = 10'b0_00111_0100;
  localparam logic [9:0] BRANCH_P  = 10'b0_11111_1100;
  localparam logic [9:0] FREEZE_P  = 10'b1_00001_0001;
  localparam logic [9:0] RELEASE_P = 10'b1_11111_0000;
  localparam logic [9:0] BRREQ_P   = 10'b1_11111_1100;

  wire [9:0] outs = {DMem_Req, PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld,
                     IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush};

  logic [9:0]  sb[$];
  logic [9:0]  exp_v;
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
  logic [31:0] want_s, want_f;

  task automatic drive_idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
    EX_BranchTaken = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; DMem_Ready = 1'b0;
  endtask

  task automatic push_exp(input logic [9:0] e);
    sb.push_back(e);
    if (!Rst && !e[8]) exp_stall++;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      push_exp(RESET_P);
      @(negedge Clk);
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL reset_outs cyc %0d: got %b want %b", i, outs, exp_v);
      end
      @(posedge Clk); #1;
    end
    checks++;
    if (MemTimeout !== 1'b0 || StallCycles !== 32'd0 || FlushCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: got to=%b st=%0d fl=%0d want 0 0 0",
               MemTimeout, StallCycles, FlushCount);
    end
    Rst = 1'b0;
    push_exp(NORMAL_P);
    @(negedge Clk);
    exp_v = sb.pop_front(); checks++;
    if (outs !== exp_v) begin
      errors++; $display("FAIL reset_release: got %b want %b", outs, exp_v);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_loaduse();
    // {EX_MemRead, EX_WriteReg, ID_Rs, ID_Rt, ID_UsesRt}
    logic [16:0] tbl [6] = '{
      {1'b1, 5'd8, 5'd8, 5'd1, 1'b0},  // rs match
      {1'b0, 5'd8, 5'd8, 5'd1, 1'b0},  // load gone to MEM
      {1'b1, 5'd9, 5'd3, 5'd9, 1'b1},  // rt match, rt used
      {1'b1, 5'd9, 5'd3, 5'd9, 1'b0},  // rt match, rt unused
      {1'b1, 5'd0, 5'd0, 5'd0, 1'b1},  // $0 destination
      {1'b1, 5'd7, 5'd6, 5'd5, 1'b1}   // no match
    };
    logic [9:0] want [6] = '{LOADUSE_P, NORMAL_P, LOADUSE_P, NORMAL_P, NORMAL_P, NORMAL_P};
    for (int i = 0; i < 6; i++) begin
      {EX_MemRead, EX_WriteReg, ID_Rs, ID_Rt, ID_UsesRt} = tbl[i];
      push_exp(want[i]);
      @(negedge Clk);
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL loaduse case %0d: got %b want %b", i, outs, exp_v);
      end
      @(posedge Clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_branch();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd4; ID_Rs = 5'd4; EX_BranchTaken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      // Second cycle adds a zero-wait memory access alongside the branch.
      MEM_MemRead = (i == 1); DMem_Ready = (i == 1);
      push_exp(i == 0 ? BRANCH_P : BRREQ_P);
      exp_flush++;
      @(negedge Clk);
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL branch cyc %0d: got %b want %b", i, outs, exp_v);
      end
      @(posedge Clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_mem_wait();
    MEM_MemRead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      DMem_Ready = (i == 3);
      if (i == 4) MEM_MemRead = 1'b0;
      push_exp(i < 3 ? FREEZE_P : (i == 3 ? RELEASE_P : NORMAL_P));
      @(negedge Clk);
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL mem_wait cyc %0d: got %b want %b", i, outs, exp_v);
      end
      @(posedge Clk); #1;
    end
    checks++;
    if (MemTimeout !== 1'b0) begin
      errors++; $display("FAIL mem_wait_timeout: got %b want 0", MemTimeout);
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    MEM_MemWrite = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_exp(i < 15 ? FREEZE_P : RELEASE_P);
      @(negedge Clk);
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v || MemTimeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout cyc %0d: got %b to=%b want %b to=0", i, outs, MemTimeout, exp_v);
      end
      @(posedge Clk); #1;
    end
    MEM_MemWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(NORMAL_P);
      @(negedge Clk);
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v || MemTimeout !== 1'b1) begin
        errors++;
        $display("FAIL timeout_sticky cyc %0d: got %b to=%b want %b to=1",
                 i, outs, MemTimeout, exp_v);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] want [4] = '{LOADUSE_P, BRANCH_P, FREEZE_P, RELEASE_P};
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      unique case (i)
        0: begin EX_MemRead = 1'b1; EX_WriteReg = 5'd12; ID_Rs = 5'd12; end
        1: EX_BranchTaken = 1'b1;
        2: MEM_MemWrite = 1'b1;
        default: begin MEM_MemWrite = 1'b1; DMem_Ready = 1'b1; EX_BranchTaken = 1'b1; end
      endcase
      push_exp(want[i]);
      if (i == 1) exp_flush++;
      @(negedge Clk);
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL back_to_back cyc %0d: got %b want %b", i, outs, exp_v);
      end
      @(posedge Clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_counters();
`ifdef PIPE_PERF_CNT_EN
    want_s = 32'(exp_stall); want_f = 32'(exp_flush);
`else
    want_s = 32'd0; want_f = 32'd0;
`endif
    @(negedge Clk);
    checks++;
    if (StallCycles !== want_s || FlushCount !== want_f) begin
      errors++;
      $display("FAIL counters: got st=%0d fl=%0d want st=%0d fl=%0d",
               StallCycles, FlushCount, want_s, want_f);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    MEM_MemRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Rst = (i == 2);
      if (i == 3) drive_idle();
      // Last cycle: a stale MEM_WAIT would still freeze, RUN advances normally.
      push_exp(i < 2 ? FREEZE_P : (i == 2 ? RESET_P : NORMAL_P));
      @(negedge Clk);
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL reset_mid_wait cyc %0d: got %b want %b", i, outs, exp_v);
      end
      @(posedge Clk); #1;
    end
    checks++;
    if (MemTimeout !== 1'b0 || StallCycles !== 32'd0 || FlushCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_wait_regs: got to=%b st=%0d fl=%0d want 0 0 0",
               MemTimeout, StallCycles, FlushCount);
    end
  endtask

  initial begin
    Rst = 1'b1;
    drive_idle();
    test_reset();
    test_loaduse();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    test_counters();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the Ld and Flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and taken branch/jump redirects. It also freezes the pipe through a request/ready handshake while a multicycle data-memory access in MEM completes. Each Flush output is ORed with Rst at the top level into the corresponding pipeline register's Rst input.

Parameters:
MEM_TIMEOUT, 15, max wait cycles in MEM_WAIT before forced completion
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
Clk  in  1  clock; all state updates on posedge
Rst  in  1  reset, synchronous, active-high
ID_Rs  in  5  rs field of instruction in ID
ID_Rt  in  5  rt field of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt
EX_MemRead  in  1  EX instruction is a load
EX_WriteReg  in  5  destination register of EX instruction
EX_BranchTaken  in  1  branch/jump resolved taken in EX
MEM_MemRead  in  1  MEM instruction reads data memory
MEM_MemWrite  in  1  MEM instruction writes data memory
DMem_Ready  in  1  data memory completes current access this cycle
DMem_Req  out  1  data memory access request
PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld  out  1 each  register load enables
IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush  out  1 each  synchronous clear to bubble
MemTimeout  out  1  sticky; a memory access exceeded MEM_TIMEOUT
StallCycles  out  32  perf counter (see Optional Feature)
FlushCount  out  32  perf counter (see Optional Feature)

Behaviour:
- State register: RUN, MEM_WAIT. Wait counter wcnt is CNT_W bits wide.
- All Ld/Flush/DMem_Req outputs are combinational from the current state and inputs, so they act in the same cycle. State, wcnt, MemTimeout and counters are registered.
- Rst=1: state<=RUN, wcnt<=0, MemTimeout<=0, counters<=0. Outputs while Rst=1: all Ld=0, all Flush=1, DMem_Req=0.
- memacc = MEM_MemRead | MEM_MemWrite.
- loaduse = EX_MemRead & (EX_WriteReg!=0) & ((EX_WriteReg==ID_Rs) | (ID_UsesRt & EX_WriteReg==ID_Rt)).
- Priority: memory stall > branch flush > load-use > normal.
- RUN, memacc & !DMem_Ready:
  - DMem_Req=1, all Ld=0, MEMWB_Ld=1 with MEMWB_Flush=1 (bubble into WB), other Flushes=0.
  - Next state MEM_WAIT, wcnt<=1.
- RUN, memacc & DMem_Ready: DMem_Req=1, zero-stall completion, normal advance. Branch/load-use rules still apply this cycle.
- MEM_WAIT:
  - DMem_Req=1, same freeze outputs as above.
  - On DMem_Ready: all Ld=1, no flush (pipe advances), state<=RUN, wcnt<=0.
  - Else if wcnt==MEM_TIMEOUT: MemTimeout<=1, treat as complete (same outputs as DMem_Ready), state<=RUN.
  - Else wcnt<=wcnt+1.
  - EX_BranchTaken and loaduse are ignored while frozen; their inputs are held and are acted on after release.
- Branch (RUN, no memory stall, EX_BranchTaken):
  - All Ld=1, IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=0.
  - The EX instruction proceeds, and PC loads the target.
  - A simultaneous loaduse is discarded, because the ID instruction is flushed.
- Load-use (RUN, no stall, no branch, loaduse):
  - PC_Ld=0, IFID_Ld=0, IDEX_Ld=1 with IDEX_Flush=1, EXMEM_Ld=1, MEMWB_Ld=1.
  - Exactly one bubble; the next cycle has no hazard because the load has moved to MEM.
- Normal: all Ld=1, all Flush=0, DMem_Req=memacc.
- Register $0 as load destination never stalls.
- A Rst asserted in MEM_WAIT aborts the access: DMem_Req drops the same cycle and the state returns to RUN.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: StallCycles increments on every cycle with PC_Ld=0 and Rst=0. FlushCount increments on every branch-flush cycle. Both are 32-bit and wrap at 2^32-1 to 0.
- Undefined: no counter registers; StallCycles=0 and FlushCount=0 constantly.

Test Plan:
- Rst for 2 cycles -> all Flush=1, all Ld=0, DMem_Req=0. First cycle after release with idle inputs -> all Ld=1, Flush=0.
- EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 -> one cycle PC_Ld=0, IFID_Ld=0, IDEX_Flush=1. Next cycle (EX_MemRead=0) is normal. Repeat with EX_WriteReg=0 -> no stall.
- EX_BranchTaken=1 with loaduse also true -> IFID_Flush=1, IDEX_Flush=1, PC_Ld=1, no load-use bubble.
- MEM_MemRead=1, DMem_Ready low for 3 cycles then high -> DMem_Req=1 for 4 cycles, 3 frozen cycles with MEMWB_Flush=1, release on the 4th, MemTimeout=0.
- MEM_MemWrite=1, DMem_Ready never high, MEM_TIMEOUT=15 -> forced release after 16 cycles in total, MemTimeout=1 and sticky until Rst.
- With PIPE_PERF_CNT_EN: the above sequence gives StallCycles equal to the summed frozen/bubble cycles and FlushCount=1. Rst asserted mid-MEM_WAIT -> DMem_Req=0 in the same cycle, state RUN.
